// File: rtl/dekatron_pkg.sv
// Shared types and helpers for the dekatron step sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dekatron_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        G1     = 3'd2,
        G2     = 3'd3,
        SETTLE = 3'd4
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Phase timer must hold the larger of the two programmable durations.
    function automatic int timer_w(input int pulse_len, input int settle_len);
        int m;
        m = (pulse_len > settle_len) ? pulse_len : settle_len;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] v);
        return (v == BCD_MAX) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] v);
        return (v == 4'd0) ? BCD_MAX : v - 4'd1;
    endfunction

endpackage

// File: rtl/dekatron_step_ctrl_if.sv
// Request/status bundle between the datapath and one dekatron sequencer.
// Latency: n/a (wires only).
// Backpressure: requester must hold off while Ready=0; nothing is queued.
interface dekatron_step_ctrl_if;
    logic       Request;
    logic       Dec;
    logic       Set;
    logic [3:0] In;
    logic       Ready;
    logic       Guide1;
    logic       Guide2;
    logic [3:0] Pos;
    logic [9:0] Out;
    logic       Carry;

    modport master (
        output Request, Dec, Set, In,
        input  Ready, Guide1, Guide2, Pos, Out, Carry
    );

    modport slave (
        input  Request, Dec, Set, In,
        output Ready, Guide1, Guide2, Pos, Out, Carry
    );
endinterface

// File: rtl/dekatron_phase_timer.sv
// Loadable down-counter timing one guide phase or the settle interval.
// Latency: done asserts on the load_val-th cycle after a load (count reaches 1).
// Backpressure: none; a load always wins over counting.
module dekatron_phase_timer #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Reload on phase entry, otherwise count down and park at 1.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt > W'(1)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/dekatron_step_ctrl.sv
// Dekatron tube sequencer: inc/dec/set requests drive ordered guide phases, track BCD glow position.
// Latency: one step = 2*PULSE_LEN+SETTLE_LEN cycles; set = 1 + steps*(2*PULSE_LEN+SETTLE_LEN) cycles.
// Backpressure: Ready=0 while busy; requests seen then are dropped. Optional wrap pulse: DEKATRON_CARRY_EN.
module dekatron_step_ctrl
    import dekatron_pkg::*;
#(
    parameter int PULSE_LEN  = 2,
    parameter int SETTLE_LEN = 3
) (
    input  logic                Clk,
    input  logic                Rst,
    dekatron_step_ctrl_if.slave bus
);

    localparam int            TW        = timer_w(PULSE_LEN, SETTLE_LEN);
    localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE_LEN);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_LEN);

    state_t        state;
    logic          rev;        // current step runs G2 -> G1
    logic          set_mode;   // stepping toward a Set target
    logic [3:0]    target;
    logic [3:0]    pos;
    logic          ready_q;
    logic          g1_q;
    logic          g2_q;

    logic          last_phase;
    logic          tmr_load;
    logic          tmr_done;
    logic [TW-1:0] tmr_val;

    // Every phase exit happens on tmr_done and every entry comes from IDLE,
    // CHECK or an expiring phase, so the timer can be reloaded in exactly
    // those cycles with the duration of whatever phase follows.
    assign last_phase = ((state == G2) && !rev) || ((state == G1) && rev);
    assign tmr_load   = (state == IDLE) || (state == CHECK) || tmr_done;
    assign tmr_val    = last_phase ? SETTLE_LD : PULSE_LD;

    dekatron_phase_timer #(.W(TW)) u_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Step sequencer with registered Ready/guide outputs.
    // In a Set, the last settle cycle also performs the target compare, so
    // only the initial CHECK costs a dedicated cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            rev      <= 1'b0;
            set_mode <= 1'b0;
            target   <= 4'd0;
            pos      <= 4'd0;
            ready_q  <= 1'b1;
            g1_q     <= 1'b0;
            g2_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Request) begin
                        if (bus.Set) begin
                            if (bus.In <= BCD_MAX) begin
                                target   <= bus.In;
                                set_mode <= 1'b1;
                                rev      <= 1'b0;
                                ready_q  <= 1'b0;
                                state    <= CHECK;
                            end
                        end else if (bus.Dec) begin
                            rev      <= 1'b1;
                            set_mode <= 1'b0;
                            ready_q  <= 1'b0;
                            g2_q     <= 1'b1;
                            state    <= G2;
                        end else begin
                            rev      <= 1'b0;
                            set_mode <= 1'b0;
                            ready_q  <= 1'b0;
                            g1_q     <= 1'b1;
                            state    <= G1;
                        end
                    end
                end
                CHECK: begin
                    if (pos == target) begin
                        set_mode <= 1'b0;
                        ready_q  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        g1_q  <= 1'b1;
                        state <= G1;
                    end
                end
                G1: begin
                    if (tmr_done) begin
                        g1_q <= 1'b0;
                        if (rev) begin
                            pos   <= bcd_dec(pos);
                            state <= SETTLE;
                        end else begin
                            g2_q  <= 1'b1;
                            state <= G2;
                        end
                    end
                end
                G2: begin
                    if (tmr_done) begin
                        g2_q <= 1'b0;
                        if (!rev) begin
                            pos   <= bcd_inc(pos);
                            state <= SETTLE;
                        end else begin
                            g1_q  <= 1'b1;
                            state <= G1;
                        end
                    end
                end
                SETTLE: begin
                    if (tmr_done) begin
                        if (set_mode && (pos != target)) begin
                            g1_q  <= 1'b1;
                            state <= G1;
                        end else begin
                            set_mode <= 1'b0;
                            ready_q  <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    g1_q    <= 1'b0;
                    g2_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef DEKATRON_CARRY_EN
    logic carry_q;
    logic wrap_evt;

    // Wrap is only reported for plain inc/dec; Set never reports one.
    assign wrap_evt = tmr_done && !set_mode &&
                      (((state == G2) && !rev && (pos == BCD_MAX)) ||
                       ((state == G1) &&  rev && (pos == 4'd0)));

    // One-cycle pulse aligned with the first cycle showing the wrapped Pos.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= wrap_evt;
        end
    end

    assign bus.Carry = carry_q;
`else
    assign bus.Carry = 1'b0;
`endif

    assign bus.Ready  = ready_q;
    assign bus.Guide1 = g1_q;
    assign bus.Guide2 = g2_q;
    assign bus.Pos    = pos;
    assign bus.Out    = 10'd1 << pos;

endmodule

// File: tb/tb_dekatron_step_ctrl.sv
// Directed bench for dekatron_step_ctrl with default timing (PULSE_LEN=2, SETTLE_LEN=3).
// Latency: n/a.
// Backpressure: requests are only issued while Ready=1, except where ignoring them is the point.
module tb_dekatron_step_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

`ifdef DEKATRON_CARRY_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    dekatron_step_ctrl_if bus();

    dekatron_step_ctrl #(.PULSE_LEN(2), .SETTLE_LEN(3)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       dec;
        logic       set;
        logic [3:0] in;
        int         exp_pos;
        int         exp_low;    // cycles with Ready=0
        int         exp_g1;     // cycles with Guide1=1
        int         exp_g2;     // cycles with Guide2=1
        int         exp_first;  // 0 none, 1 Guide1 first, 2 Guide2 first
        int         wrap;       // inc/dec wrap (Carry expected if enabled)
    } vec_t;

    vec_t vt[10];
    int   vectors     = 0;
    int   miscompares = 0;
    int   overlap     = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count busy-cycle activity until Ready returns, bounded.
    task automatic wait_ready(output int low, output int g1c, output int g2c,
                              output int first, output int carc);
        low = 0; g1c = 0; g2c = 0; first = 0; carc = 0;
        while (!bus.Ready && low < 200) begin
            if (bus.Guide1) g1c++;
            if (bus.Guide2) g2c++;
            if (first == 0 && bus.Guide1) first = 1;
            else if (first == 0 && bus.Guide2) first = 2;
            if (bus.Carry) carc++;
            tick();
            low++;
        end
        if (!bus.Ready) chk("ready_timeout", int'(bus.Ready), 1);
    endtask

    // Guides must never overlap.
    always @(negedge clk) begin
        assert (!(bus.Guide1 && bus.Guide2)) else begin
            overlap++;
            $display("FAIL guide_overlap: both guides high at %0t", $time);
        end
    end

    initial begin
        int low, g1c, g2c, first, carc;

        vt[0] = '{1'b0, 1'b0, 4'd0,  1,  7,  2,  2, 1, 0};  // inc 0->1
        vt[1] = '{1'b1, 1'b0, 4'd0,  0,  7,  2,  2, 2, 0};  // dec 1->0
        vt[2] = '{1'b1, 1'b0, 4'd0,  9,  7,  2,  2, 2, 1};  // dec 0->9 wrap
        vt[3] = '{1'b0, 1'b0, 4'd0,  0,  7,  2,  2, 1, 1};  // inc 9->0 wrap
        vt[4] = '{1'b0, 1'b1, 4'd7,  7, 50, 14, 14, 1, 0};  // set 7: 7 steps
        vt[5] = '{1'b1, 1'b1, 4'd2,  2, 36, 10, 10, 1, 0};  // set 2 from 7: 5 steps, Dec overridden
        vt[6] = '{1'b0, 1'b1, 4'd2,  2,  1,  0,  0, 0, 0};  // set to current
        vt[7] = '{1'b0, 1'b1, 4'd12, 2,  0,  0,  0, 0, 0};  // invalid BCD ignored
        vt[8] = '{1'b0, 1'b1, 4'd4,  4, 15,  4,  4, 1, 0};  // set 4 from 2: 2 steps
        vt[9] = '{1'b0, 1'b1, 4'd4,  4,  1,  0,  0, 0, 0};  // set 4 at 4

        bus.Request = 1'b0; bus.Dec = 1'b0; bus.Set = 1'b0; bus.In = 4'd0;
        rst = 1'b1;
        tick(); tick();
        chk("rst_ready",  int'(bus.Ready),  1);
        chk("rst_pos",    int'(bus.Pos),    0);
        chk("rst_out",    int'(bus.Out),    1);
        chk("rst_guide1", int'(bus.Guide1), 0);
        chk("rst_guide2", int'(bus.Guide2), 0);
        chk("rst_carry",  int'(bus.Carry),  0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            bus.Request = 1'b1; bus.Dec = vt[i].dec; bus.Set = vt[i].set; bus.In = vt[i].in;
            tick();
            bus.Request = 1'b0; bus.Dec = 1'b0; bus.Set = 1'b0; bus.In = 4'd0;
            wait_ready(low, g1c, g2c, first, carc);
            chk($sformatf("v%0d_pos", i),   int'(bus.Pos), vt[i].exp_pos);
            chk($sformatf("v%0d_out", i),   int'(bus.Out), 1 << vt[i].exp_pos);
            chk($sformatf("v%0d_low", i),   low,   vt[i].exp_low);
            chk($sformatf("v%0d_g1", i),    g1c,   vt[i].exp_g1);
            chk($sformatf("v%0d_g2", i),    g2c,   vt[i].exp_g2);
            chk($sformatf("v%0d_first", i), first, vt[i].exp_first);
            chk($sformatf("v%0d_carry", i), carc,  vt[i].wrap * CE);
            tick();
        end

        // Cycle-exact increment 4 -> 5.
        bus.Request = 1'b1;
        tick();
        bus.Request = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("inc_c%0d_g1", k),    int'(bus.Guide1), (k <= 2) ? 1 : 0);
            chk($sformatf("inc_c%0d_g2", k),    int'(bus.Guide2), (k == 3 || k == 4) ? 1 : 0);
            chk($sformatf("inc_c%0d_pos", k),   int'(bus.Pos),    (k >= 5) ? 5 : 4);
            chk($sformatf("inc_c%0d_ready", k), int'(bus.Ready),  (k == 8) ? 1 : 0);
            if (k < 8) tick();
        end
        tick();

        // Reset during G2 of a step from Pos=5.
        bus.Request = 1'b1;
        tick();
        bus.Request = 1'b0;
        tick(); tick();
        chk("rstmid_in_g2", int'(bus.Guide2), 1);
        rst = 1'b1;
        tick();
        chk("rstmid_pos",    int'(bus.Pos),    0);
        chk("rstmid_guide1", int'(bus.Guide1), 0);
        chk("rstmid_guide2", int'(bus.Guide2), 0);
        chk("rstmid_ready",  int'(bus.Ready),  1);
        rst = 1'b0;
        tick();

        // Input noise while busy must not disturb an increment 0 -> 1.
        bus.Request = 1'b1; bus.Dec = 1'b0; bus.Set = 1'b0;
        tick();
        low = 0;
        while (!bus.Ready && low < 200) begin
            bus.Request = 1'($urandom_range(0, 1));
            bus.Dec     = 1'($urandom_range(0, 1));
            bus.Set     = 1'($urandom_range(0, 1));
            bus.In      = 4'($urandom_range(0, 15));
            tick();
            low++;
        end
        bus.Request = 1'b0; bus.Dec = 1'b0; bus.Set = 1'b0; bus.In = 4'd0;
        chk("noise_low", low, 7);
        chk("noise_pos", int'(bus.Pos), 1);
        tick();

        // Request held high re-issues on the first Ready=1 cycle.
        bus.Request = 1'b1;
        tick();
        wait_ready(low, g1c, g2c, first, carc);
        chk("b2b_low1", low, 7);
        chk("b2b_pos1", int'(bus.Pos), 2);
        tick();
        chk("b2b_reissue", int'(bus.Ready), 0);
        bus.Request = 1'b0;
        wait_ready(low, g1c, g2c, first, carc);
        chk("b2b_low2", low, 7);
        chk("b2b_pos2", int'(bus.Pos), 3);

        chk("guide_overlap", overlap, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
